// File: rtl/datapath_sequencer.sv
// datapath_sequencer: Moore control-step sequencer for the register-transfer datapath.
// Accepts one three-register instruction at a time and walks it through the fixed
// micro-step sequence: operand loads, ALU or mul/div execution, result write-back.
//
// Ports:
//   clock              system clock, rising edge
//   clear              asynchronous reset, active-low
//   start              instruction request, sampled only in IDLE
//   op, ra, rb, rc     operation, destination, source 1, source 2
//   Rin, Rout          one-hot R0-R15 load enables / bus drives
//   RAin .. LOout      datapath strobes
//   Op                 ALU operation select (latched op, 0 in IDLE)
//   busy               high in every non-IDLE state
//   done               one-cycle completion pulse
module datapath_sequencer #(
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  input  logic [3:0]  rc,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        RAin,
  output logic        RBin,
  output logic        RZin,
  output logic        RZout,
  output logic        HIin,
  output logic        LOin,
  output logic        HIout,
  output logic        LOout,
  output logic [3:0]  Op,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);
  localparam logic [3:0] OP_ALU_MAX = 4'hB;
  localparam logic [3:0] OP_MFHI    = 4'hE;
  localparam logic [3:0] OP_MFLO    = 4'hF;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_WB, S_WAIT, S_HILO, S_MOVE, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       op_q, op_d, ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [15:0] rin_d, rout_d;
  logic        ra_in_d, rb_in_d, rz_in_d, rz_out_d;
  logic        hi_in_d, lo_in_d, hi_out_d, lo_out_d;
  logic [3:0]  op_out_d;
  logic        busy_d, done_d;

  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'(16'd1 << idx);
  endfunction

  // State, latched fields, counter and registered strobes.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
      cnt_q   <= '0;
      Rin     <= '0;
      Rout    <= '0;
      RAin    <= 1'b0;
      RBin    <= 1'b0;
      RZin    <= 1'b0;
      RZout   <= 1'b0;
      HIin    <= 1'b0;
      LOin    <= 1'b0;
      HIout   <= 1'b0;
      LOout   <= 1'b0;
      Op      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
      cnt_q   <= cnt_d;
      Rin     <= rin_d;
      Rout    <= rout_d;
      RAin    <= ra_in_d;
      RBin    <= rb_in_d;
      RZin    <= rz_in_d;
      RZout   <= rz_out_d;
      HIin    <= hi_in_d;
      LOin    <= lo_in_d;
      HIout   <= hi_out_d;
      LOout   <= lo_out_d;
      Op      <= op_out_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Next state, then strobes decoded from the next state so the registered
  // outputs line up exactly with the state they belong to.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    rc_d     = rc_q;
    cnt_d    = cnt_q;
    rin_d    = '0;
    rout_d   = '0;
    ra_in_d  = 1'b0;
    rb_in_d  = 1'b0;
    rz_in_d  = 1'b0;
    rz_out_d = 1'b0;
    hi_in_d  = 1'b0;
    lo_in_d  = 1'b0;
    hi_out_d = 1'b0;
    lo_out_d = 1'b0;
    op_out_d = '0;
    busy_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d = op;
          ra_d = ra;
          rb_d = rb;
          rc_d = rc;
          state_d = (op == OP_MFHI || op == OP_MFLO) ? S_MOVE : S_LOAD_A;
        end
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: begin
        if (op_q <= OP_ALU_MAX) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      S_EXEC: state_d = S_WB;
      S_WB:   state_d = S_DONE;
      // Counter starts at LAT-1, so WAIT lasts exactly LAT cycles.
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_HILO;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_HILO: state_d = S_DONE;
      S_MOVE: state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_LOAD_A: begin
        rout_d  = onehot16(rb_d);
        ra_in_d = 1'b1;
      end
      S_LOAD_B: begin
        rout_d  = onehot16(rc_d);
        rb_in_d = 1'b1;
      end
      S_EXEC: rz_in_d = 1'b1;
      S_WB: begin
        rz_out_d = 1'b1;
        rin_d    = onehot16(ra_d);
      end
      S_HILO: begin
        hi_in_d = 1'b1;
        lo_in_d = 1'b1;
      end
      S_MOVE: begin
        hi_out_d = (op_d == OP_MFHI);
        lo_out_d = (op_d == OP_MFLO);
        rin_d    = onehot16(ra_d);
      end
      S_DONE: done_d = 1'b1;
      default: ;
    endcase

    if (state_d != S_IDLE) begin
      op_out_d = op_d;
      busy_d   = 1'b1;
    end
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Testbench for datapath_sequencer: directed scenarios plus randomized instructions,
// checked cycle by cycle against a queue-based expected-strobe model.
module tb_datapath_sequencer;

  localparam int unsigned LAT = 4;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic ra_in, rb_in, rz_in, rz_out, hi_in, lo_in, hi_out, lo_out;
    logic [3:0] op;
    logic busy, done;
  } obs_t;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = '0, ra = '0, rb = '0, rc = '0;
  logic [15:0] Rin, Rout;
  logic        RAin, RBin, RZin, RZout, HIin, LOin, HIout, LOout;
  logic [3:0]  Op;
  logic        busy, done;

  datapath_sequencer #(.MULDIV_LAT(LAT)) dut (
    .clock(clock), .clear(clear), .start(start), .op(op), .ra(ra), .rb(rb), .rc(rc),
    .Rin(Rin), .Rout(Rout), .RAin(RAin), .RBin(RBin), .RZin(RZin), .RZout(RZout),
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout), .Op(Op),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  int   n_chk = 0, n_fail = 0;
  int   n_acc = 0, n_done = 0;
  obs_t exp_cur = '0;
  obs_t exp_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic obs_t observed();
    obs_t v;
    v = '{rin: Rin, rout: Rout, ra_in: RAin, rb_in: RBin, rz_in: RZin, rz_out: RZout,
          hi_in: HIin, lo_in: LOin, hi_out: HIout, lo_out: LOout, op: Op,
          busy: busy, done: done};
    return v;
  endfunction

  // Expected per-cycle strobes for one instruction, straight from the step list.
  task automatic model_accept(input logic [3:0] o, a, b, c);
    obs_t base, v;
    logic [15:0] one;
    one = 16'd1;
    base = '0;
    base.op = o;
    base.busy = 1'b1;
    if (o == 4'hE || o == 4'hF) begin
      v = base; v.rin = one << a; v.hi_out = (o == 4'hE); v.lo_out = (o == 4'hF);
      exp_q.push_back(v);
    end else begin
      v = base; v.rout = one << b; v.ra_in = 1'b1; exp_q.push_back(v);
      v = base; v.rout = one << c; v.rb_in = 1'b1; exp_q.push_back(v);
      if (o <= 4'hB) begin
        v = base; v.rz_in = 1'b1; exp_q.push_back(v);
        v = base; v.rz_out = 1'b1; v.rin = one << a; exp_q.push_back(v);
      end else begin
        for (int i = 0; i < int'(LAT); i++) exp_q.push_back(base);
        v = base; v.hi_in = 1'b1; v.lo_in = 1'b1; exp_q.push_back(v);
      end
    end
    v = base; v.done = 1'b1; exp_q.push_back(v);
  endtask

  task automatic check_cycle();
    obs_t d;
    d = observed();
    chk("outputs", 64'(d), 64'(exp_cur));
    chk("rin_onehot0", 64'($onehot0(Rin)), 64'd1);
    chk("rout_onehot0", 64'($onehot0(Rout)), 64'd1);
    chk("bus_drivers", 64'(($countones(Rout) + int'(RZout) + int'(HIout) + int'(LOout)) <= 1), 64'd1);
    if (done) n_done++;
  endtask

  // One clock: drive inputs, advance the model on the edge, check just after it.
  task automatic step(input logic s, input logic [3:0] o, a, b, c);
    start = s; op = o; ra = a; rb = b; rc = c;
    @(posedge clock);
    if (!clear) begin
      exp_q.delete();
      exp_cur = '0;
    end else begin
      if (!exp_cur.busy && s) begin
        model_accept(o, a, b, c);
        n_acc++;
      end
      exp_cur = (exp_q.size() > 0) ? exp_q.pop_front() : obs_t'('0);
    end
    #1;
    check_cycle();
  endtask

  // Issue one instruction and measure cycles to done; optional start pulse at poke.
  task automatic run_instr(input string tag, input logic [3:0] o, a, b, c,
                           input int want_lat, input int poke);
    int n;
    step(1'b1, o, a, b, c);
    n = 1;
    while (!done && n < 40) begin
      step(n == poke, (n == poke) ? 4'h3 : o, a, b, c);
      n++;
    end
    chk(tag, 64'(n), 64'(want_lat));
    step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
  endtask

  initial begin
    int cyc;
    #1 clear = 1'b0;
    #1 chk("reset_outputs", 64'(observed()), 64'd0);
    step(1'b1, 4'h0, 4'd3, 4'd1, 4'd2);
    step(1'b1, 4'h0, 4'd3, 4'd1, 4'd2);
    #2 clear = 1'b1;

    run_instr("lat_alu", 4'h0, 4'd3, 4'd1, 4'd2, 5, -1);
    run_instr("lat_mul", 4'hC, 4'd5, 4'd6, 4'd7, 4 + int'(LAT), -1);
    run_instr("lat_mflo", 4'hF, 4'd15, 4'd0, 4'd0, 2, -1);
    run_instr("lat_mfhi", 4'hE, 4'd0, 4'd9, 4'd9, 2, -1);
    run_instr("lat_div_poke", 4'hD, 4'd1, 4'd2, 4'd3, 4 + int'(LAT), 4);
    run_instr("lat_same_regs", 4'h7, 4'd4, 4'd4, 4'd4, 5, -1);

    // Abort mid-EXEC: outputs must drop before the next edge.
    step(1'b1, 4'h5, 4'd8, 4'd9, 4'd10);
    step(1'b0, 4'h0, 4'd0, 4'd0, 4'd0);
    step(1'b0, 4'h0, 4'd0, 4'd0, 4'd0);
    chk("in_exec", 64'(RZin), 64'd1);
    #2 clear = 1'b0;
    #1 chk("abort_outputs", 64'(observed()), 64'd0);
    step(1'b1, 4'h1, 4'd1, 4'd1, 4'd1);
    step(1'b0, 4'h0, 4'd0, 4'd0, 4'd0);
    #2 clear = 1'b1;
    step(1'b0, 4'h0, 4'd0, 4'd0, 4'd0);
    run_instr("lat_after_abort", 4'h2, 4'd0, 4'd11, 4'd12, 5, -1);

    // Held start: back-to-back acceptance with one IDLE cycle in between.
    for (int i = 0; i < 13; i++) step(1'b1, 4'hF, 4'd2, 4'd0, 4'd0);
    step(1'b0, 4'h0, 4'd0, 4'd0, 4'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 4'd0, 4'd0, 4'd0);

    n_acc = 0;
    n_done = 0;
    cyc = 0;
    while (n_acc < 1000 && cyc < 40000) begin
      step(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      cyc++;
    end
    chk("random_budget", 64'(n_acc >= 1000), 64'd1);
    for (int i = 0; i < int'(LAT) + 8; i++) step(1'b0, 4'h0, 4'd0, 4'd0, 4'd0);
    chk("done_count", 64'(n_done), 64'(n_acc));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
